ctrl_decode_stage: RTL and testbench

CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

---
 rtl/ctrl_decode_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_ctrl_decode_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_stage.sv
// Decode stage: decodes RV32I (optionally RV32M) instructions into a control word and
// immediate, and buffers decoded entries in a small valid/ready FIFO toward execute.
module ctrl_decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 2,
    parameter bit          ENABLE_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [23:0]     ctrl_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic [3:0] aluop;
    logic [2:0] cmpop;
    logic       load_regfile;
    logic [2:0] regfilemux_sel;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic       cmpmux_sel;
    logic       illegal;
    logic [31:0] imm32;

    logic [23:0]     dec_ctrl;
    logic [XLEN-1:0] dec_imm;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        aluop          = 4'b0000;
        cmpop          = 3'b000;
        load_regfile   = 1'b0;
        regfilemux_sel = 3'd0;
        alumux1_sel    = 1'b0;
        alumux2_sel    = 3'd0;
        cmpmux_sel     = 1'b0;
        illegal        = 1'b0;
        imm32          = 32'h0;
        unique case (opcode)
            OpLui: begin
                load_regfile   = 1'b1;
                regfilemux_sel = 3'd2;
                imm32          = {instr_i[31:12], 12'h000};
            end
            OpAuipc: begin
                alumux1_sel = 1'b1;
                alumux2_sel = 3'd1;
                imm32       = {instr_i[31:12], 12'h000};
            end
            OpJal: begin
                load_regfile   = 1'b1;
                regfilemux_sel = 3'd4;
                alumux1_sel    = 1'b1;
                alumux2_sel    = 3'd5;
                imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            OpJalr: begin
                load_regfile   = 1'b1;
                regfilemux_sel = 3'd4;
                imm32          = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OpBranch: begin
                alumux1_sel = 1'b1;
                alumux2_sel = 3'd2;
                cmpop       = funct3;
                imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OpLoad: begin
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OpStore: begin
                alumux2_sel = 3'd3;
                imm32       = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OpImm: begin
                load_regfile = 1'b1;
                imm32        = {{20{instr_i[31]}}, instr_i[31:20]};
                unique case (funct3)
                    3'b010, 3'b011: begin
                        // slti -> blt, sltiu -> bltu; result comes from the comparator
                        cmpop          = funct3[0] ? 3'b110 : 3'b100;
                        regfilemux_sel = 3'd1;
                        cmpmux_sel     = 1'b1;
                    end
                    3'b001: begin
                        aluop   = 4'b0001;
                        illegal = (funct7 != F7Base);
                    end
                    3'b101: begin
                        if (funct7 == F7Base) begin
                            aluop = 4'b0101;
                        end else if (funct7 == F7Alt) begin
                            aluop = 4'b0010;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: aluop = {1'b0, funct3};
                endcase
            end
            OpReg: begin
                load_regfile = 1'b1;
                alumux2_sel  = 3'd4;
                if (funct7 == F7Base) begin
                    if (funct3 == 3'b010 || funct3 == 3'b011) begin
                        cmpop          = funct3[0] ? 3'b110 : 3'b100;
                        regfilemux_sel = 3'd1;
                    end else begin
                        aluop = {1'b0, funct3};
                    end
                end else if (funct7 == F7Alt) begin
                    if (funct3 == 3'b000) begin
                        aluop = 4'b0011;
                    end else if (funct3 == 3'b101) begin
                        aluop = 4'b0010;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (funct7 == F7Mul && ENABLE_M) begin
                    aluop = {1'b1, funct3};
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        // Illegal entries keep only the opcode so execute treats them as bubbles
        if (illegal) begin
            aluop          = 4'b0000;
            cmpop          = 3'b000;
            load_regfile   = 1'b0;
            regfilemux_sel = 3'd0;
            alumux1_sel    = 1'b0;
            alumux2_sel    = 3'd0;
            cmpmux_sel     = 1'b0;
        end
    end

    assign dec_ctrl = {opcode, aluop, cmpop, load_regfile, regfilemux_sel, alumux1_sel,
                       alumux2_sel, cmpmux_sel, illegal};
    assign dec_imm  = XLEN'($signed(imm32));

    logic [CW-1:0] cnt_q;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic          push;
    logic          pop;

    logic [23:0]     ctrl_mem [DEPTH];
    logic [14:0]     idx_mem  [DEPTH];
    logic [XLEN-1:0] imm_mem  [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready_o  = (cnt_q < CW'(DEPTH));
    assign out_valid_o = (cnt_q != '0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage is not reset; only the occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wptr_q] <= dec_ctrl;
            idx_mem[wptr_q]  <= {instr_i[11:7], instr_i[19:15], instr_i[24:20]};
            imm_mem[wptr_q]  <= dec_imm;
            pc_mem[wptr_q]   <= pc_i;
        end
    end

    assign ctrl_o                = ctrl_mem[rptr_q];
    assign {rd_o, rs1_o, rs2_o}  = idx_mem[rptr_q];
    assign imm_o                 = imm_mem[rptr_q];
    assign pc_o                  = pc_mem[rptr_q];

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: a 32-bit/no-M and a 64-bit/M instance share stimulus;
// fixed vectors, directed handshake/flush/reset sequences, then random traffic vs a model.
module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [63:0] pc = 64'h0;

    logic        rdy0, vld0, rdy1, vld1;
    logic [23:0] ctrl0, ctrl1;
    logic [4:0]  rd0, rs10, rs20, rd1, rs11, rs21;
    logic [31:0] imm0, pco0;
    logic [63:0] imm1, pco1;

    ctrl_decode_stage #(.XLEN(32), .DEPTH(2), .ENABLE_M(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy0),
        .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(vld0), .out_ready_i(out_ready),
        .ctrl_o(ctrl0), .rd_o(rd0), .rs1_o(rs10), .rs2_o(rs20), .imm_o(imm0), .pc_o(pco0)
    );

    ctrl_decode_stage #(.XLEN(64), .DEPTH(2), .ENABLE_M(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .instr_i(instr), .pc_i(pc), .out_valid_o(vld1), .out_ready_i(out_ready),
        .ctrl_o(ctrl1), .rd_o(rd1), .rs1_o(rs11), .rs2_o(rs21), .imm_o(imm1), .pc_o(pco1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic [23:0] ctrl_m0;
        logic [23:0] ctrl_m1;
        logic [63:0] imm;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    vec_t vecs[$];
    ent_t q[$];

    function automatic logic [23:0] pack(input logic [6:0] op, input logic [3:0] alu,
                                         input logic [2:0] cmp, input logic ld,
                                         input logic [2:0] rfm, input logic a1,
                                         input logic [2:0] a2, input logic cm,
                                         input logic ill);
        return {op, alu, cmp, ld, rfm, a1, a2, cm, ill};
    endfunction

    // Reference decode: name the instruction class, then look up its control fields
    function automatic logic [23:0] ref_ctrl(input logic [31:0] ins, input bit en_m);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] alu;
        logic [2:0] cmp, rfm, a2;
        logic       ld, a1, cm, ill;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        alu = 4'h0; cmp = 3'd0; rfm = 3'd0; a2 = 3'd0; ld = 1'b0; a1 = 1'b0; cm = 1'b0;
        ill = 1'b0;
        case (op)
            7'h37: begin ld = 1'b1; rfm = 3'd2; end
            7'h17: begin a1 = 1'b1; a2 = 3'd1; end
            7'h6F: begin ld = 1'b1; rfm = 3'd4; a1 = 1'b1; a2 = 3'd5; end
            7'h67: begin ld = 1'b1; rfm = 3'd4; end
            7'h63: begin a1 = 1'b1; a2 = 3'd2; cmp = f3; end
            7'h03: ;
            7'h23: a2 = 3'd3;
            7'h13: begin
                ld = 1'b1;
                if (f3 == 3'd2)      begin cmp = 3'b100; rfm = 3'd1; cm = 1'b1; end
                else if (f3 == 3'd3) begin cmp = 3'b110; rfm = 3'd1; cm = 1'b1; end
                else if (f3 == 3'd1) begin alu = 4'h1; ill = (f7 != 7'h00); end
                else if (f3 == 3'd5) begin
                    if (f7 == 7'h00)      alu = 4'h5;
                    else if (f7 == 7'h20) alu = 4'h2;
                    else                  ill = 1'b1;
                end else alu = {1'b0, f3};
            end
            7'h33: begin
                ld = 1'b1; a2 = 3'd4;
                if (f7 == 7'h01 && en_m)                 alu = {1'b1, f3};
                else if (f7 == 7'h20 && f3 == 3'd0)      alu = 4'h3;
                else if (f7 == 7'h20 && f3 == 3'd5)      alu = 4'h2;
                else if (f7 == 7'h00 && f3 == 3'd2)      begin cmp = 3'b100; rfm = 3'd1; end
                else if (f7 == 7'h00 && f3 == 3'd3)      begin cmp = 3'b110; rfm = 3'd1; end
                else if (f7 == 7'h00)                    alu = {1'b0, f3};
                else                                     ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (ill) return {op, 16'h0, 1'b1};
        return pack(op, alu, cmp, ld, rfm, a1, a2, cm, 1'b0);
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins);
        logic s;
        s = ins[31];
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: return {{52{s}}, ins[31:20]};
            7'h23: return {{52{s}}, ins[31:25], ins[11:7]};
            7'h63: return {{51{s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            7'h37, 7'h17: return {{32{s}}, ins[31:12], 12'h000};
            7'h6F: return {{43{s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7, 8: w[6:0] = 7'h13;
            9: w[6:0] = 7'h33;
            default: ;
        endcase
        if (w[6:0] == 7'h13 || w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string tag, input bit exp_v, input bit exp_r);
        chk({tag, ".valid0"}, 64'(vld0), 64'(exp_v));
        chk({tag, ".ready0"}, 64'(rdy0), 64'(exp_r));
        chk({tag, ".valid1"}, 64'(vld1), 64'(exp_v));
        chk({tag, ".ready1"}, 64'(rdy1), 64'(exp_r));
    endtask

    task automatic check_head(input string tag, input logic [31:0] ins, input logic [63:0] p);
        logic [63:0] e;
        e = ref_imm(ins);
        chk({tag, ".ctrl0"}, 64'(ctrl0), 64'(ref_ctrl(ins, 1'b0)));
        chk({tag, ".ctrl1"}, 64'(ctrl1), 64'(ref_ctrl(ins, 1'b1)));
        chk({tag, ".imm0"}, 64'(imm0), {32'h0, e[31:0]});
        chk({tag, ".imm1"}, imm1, e);
        chk({tag, ".pc0"}, 64'(pco0), {32'h0, p[31:0]});
        chk({tag, ".pc1"}, pco1, p);
        chk({tag, ".rd"}, 64'(rd0), 64'(ins[11:7]));
        chk({tag, ".rs1"}, 64'(rs11), 64'(ins[19:15]));
        chk({tag, ".rs2"}, 64'(rs20), 64'(ins[24:20]));
    endtask

    initial begin
        logic [23:0] c;
        bit do_push, do_pop;

        vecs.push_back('{32'h00500093, pack(7'h13, 4'h0, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0),
                         pack(7'h13, 4'h0, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0), 64'd5});
        vecs.push_back('{32'h022081B3, pack(7'h33, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1),
                         pack(7'h33, 4'h8, 3'd0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0), 64'd0});
        vecs.push_back('{32'h0220C1B3, pack(7'h33, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1),
                         pack(7'h33, 4'hC, 3'd0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0), 64'd0});
        vecs.push_back('{32'hFE000EE3, pack(7'h63, 4'h0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0),
                         pack(7'h63, 4'h0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0),
                         64'hFFFF_FFFF_FFFF_FFFC});
        vecs.push_back('{32'h0020E463, pack(7'h63, 4'h0, 3'd6, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0),
                         pack(7'h63, 4'h0, 3'd6, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0), 64'd8});
        vecs.push_back('{32'h0000007F, pack(7'h7F, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1),
                         pack(7'h7F, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1), 64'd0});
        vecs.push_back('{32'h800002B7, pack(7'h37, 4'h0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0),
                         pack(7'h37, 4'h0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0),
                         64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{32'h4030D093, pack(7'h13, 4'h2, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0),
                         pack(7'h13, 4'h2, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0), 64'h403});
        vecs.push_back('{32'h02009093, pack(7'h13, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1),
                         pack(7'h13, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1), 64'h20});
        vecs.push_back('{32'hFFF0B113, pack(7'h13, 4'h0, 3'd6, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0),
                         pack(7'h13, 4'h0, 3'd6, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0),
                         64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{32'h0020A423, pack(7'h23, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0),
                         pack(7'h23, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0), 64'd8});
        vecs.push_back('{32'hFF9FF0EF, pack(7'h6F, 4'h0, 3'd0, 1'b1, 3'd4, 1'b1, 3'd5, 1'b0, 1'b0),
                         pack(7'h6F, 4'h0, 3'd0, 1'b1, 3'd4, 1'b1, 3'd5, 1'b0, 1'b0),
                         64'hFFFF_FFFF_FFFF_FFF8});
        vecs.push_back('{32'h00008067, pack(7'h67, 4'h0, 3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0),
                         pack(7'h67, 4'h0, 3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0), 64'd0});
        vecs.push_back('{32'h402091B3, pack(7'h33, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1),
                         pack(7'h33, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1), 64'd0});
        vecs.push_back('{32'h402081B3, pack(7'h33, 4'h3, 3'd0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0),
                         pack(7'h33, 4'h3, 3'd0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0), 64'd0});
        vecs.push_back('{32'h0020C1B3, pack(7'h33, 4'h4, 3'd0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0),
                         pack(7'h33, 4'h4, 3'd0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0), 64'd0});
        vecs.push_back('{32'h0020A1B3, pack(7'h33, 4'h0, 3'd4, 1'b1, 3'd1, 1'b0, 3'd4, 1'b0, 1'b0),
                         pack(7'h33, 4'h0, 3'd4, 1'b1, 3'd1, 1'b0, 3'd4, 1'b0, 1'b0), 64'd0});
        vecs.push_back('{32'h00001097, pack(7'h17, 4'h0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0),
                         pack(7'h17, 4'h0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0), 64'h1000});
        vecs.push_back('{32'hFFC12083, pack(7'h03, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0),
                         pack(7'h03, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0),
                         64'hFFFF_FFFF_FFFF_FFFC});

        // Reset state
        #1 rst_n = 1'b0;
        #2 check_flags("reset", 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-instruction vectors into an empty buffer
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = 1'b1;
            instr = vecs[i].instr;
            pc = 64'h8000_0000_0000_1000 + 64'(i) * 64'd4;
            @(negedge clk);
            in_valid = 1'b0;
            check_flags($sformatf("vec%0d", i), 1'b1, 1'b1);
            chk($sformatf("vec%0d.ctrl_m0", i), 64'(ctrl0), 64'(vecs[i].ctrl_m0));
            chk($sformatf("vec%0d.ctrl_m1", i), 64'(ctrl1), 64'(vecs[i].ctrl_m1));
            chk($sformatf("vec%0d.imm32", i), 64'(imm0), {32'h0, vecs[i].imm[31:0]});
            chk($sformatf("vec%0d.imm64", i), imm1, vecs[i].imm);
            chk($sformatf("vec%0d.pc64", i), pco1, pc);
            chk($sformatf("vec%0d.rd", i), 64'(rd1), 64'(instr[11:7]));
            @(negedge clk);
        end
        check_flags("vec.drained", 1'b0, 1'b1);

        // Back-pressure: third instruction held until execute drains
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00500093; pc = 64'h100;
        @(negedge clk);
        check_flags("bp.one", 1'b1, 1'b1);
        instr = 32'h402081B3; pc = 64'h104;
        @(negedge clk);
        check_flags("bp.full", 1'b1, 1'b0);
        instr = 32'hFE000EE3; pc = 64'h108;
        @(negedge clk);
        check_flags("bp.held", 1'b1, 1'b0);
        check_head("bp.h0", 32'h00500093, 64'h100);
        out_ready = 1'b1;
        @(negedge clk);
        check_flags("bp.d1", 1'b1, 1'b1);
        check_head("bp.h1", 32'h402081B3, 64'h104);
        @(negedge clk);
        in_valid = 1'b0;
        check_flags("bp.d2", 1'b1, 1'b1);
        check_head("bp.h2", 32'hFE000EE3, 64'h108);
        @(negedge clk);
        check_flags("bp.empty", 1'b0, 1'b1);

        // Flush with a full buffer and a concurrent offer
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00500093;
        @(negedge clk);
        @(negedge clk);
        check_flags("fl.full", 1'b1, 1'b0);
        flush = 1'b1;
        instr = 32'h0000007F;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_flags("fl.after", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_flags($sformatf("fl.idle%0d", i), 1'b0, 1'b1);
        end
        // Flush drops a push offered in the same cycle even with room
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check_flags("fl.push", 1'b0, 1'b1);
        @(negedge clk);
        check_flags("fl.push2", 1'b0, 1'b1);

        // Asynchronous reset between edges with one entry buffered
        in_valid = 1'b1;
        instr = 32'h00500093; pc = 64'h200;
        @(negedge clk);
        in_valid = 1'b0;
        check_flags("ar.one", 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_flags("ar.async", 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        instr = 32'h0000007F; pc = 64'h204;
        @(negedge clk);
        in_valid = 1'b0;
        check_flags("ar.first", 1'b1, 1'b1);
        check_head("ar.ill", 32'h0000007F, 64'h204);
        c = ctrl0;
        chk("ar.ctrl_mid", 64'(c[16:1]), 64'h0);
        chk("ar.illegal", 64'(c[0]), 64'h1);
        out_ready = 1'b1;
        @(negedge clk);
        check_flags("ar.drained", 1'b0, 1'b1);

        // Random traffic against the queue model
        for (int cyc = 0; cyc < 800; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            instr     = gen_instr();
            pc        = {$urandom, $urandom};
            check_flags($sformatf("rnd%0d", cyc), q.size() != 0, q.size() < 2);
            if (q.size() != 0) check_head($sformatf("rnd%0d", cyc), q[0].instr, q[0].pc);
            if (flush) begin
                q.delete();
            end else begin
                do_push = in_valid && (q.size() < 2);
                do_pop  = (q.size() != 0) && out_ready;
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back('{instr, pc});
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
